matrix_issue_scheduler: RTL

- Sits between decode (matrix fields of the control unit) and the two matrix functional units: matrix load/store unit (MLS) and systolic GEMM array.
- Buffers one decoded matrix op and checks RAW/WAW/WAR hazards against a 16-entry matrix-register scoreboard.
- Checks structural availability and issues the op with valid/ready handshakes.
- In-order, single issue, at most one outstanding op per FU.

---
 rtl/matrix_issue_scheduler_if.sv | 54 +++++
 rtl/matrix_issue_scheduler.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/matrix_issue_scheduler_if.sv
// Handshake/bus bundle between decode, the matrix issue scheduler, MLS and GEMM.
// slave: the scheduler; master: decode plus the two matrix functional units.
interface matrix_issue_scheduler_if #(
    parameter int NUM_MREGS = 16,
    parameter int PERF_W    = 32
);
    localparam int RW = $clog2(NUM_MREGS);

    logic                 dec_valid;
    logic                 dec_ready;
    logic                 dec_is_gemm;
    logic [1:0]           dec_mem_type;
    logic [RW-1:0]        dec_rd;
    logic [RW-1:0]        dec_rs1;
    logic [RW-1:0]        dec_rs2;
    logic [RW-1:0]        dec_rs3;
    logic [4:0]           dec_stride;
    logic                 flush;
    logic                 mls_valid;
    logic                 mls_ready;
    logic                 mls_is_store;
    logic [RW-1:0]        mls_reg;
    logic [4:0]           mls_stride;
    logic                 mls_done;
    logic                 gemm_valid;
    logic                 gemm_ready;
    logic [RW-1:0]        gemm_rd;
    logic [RW-1:0]        gemm_rs1;
    logic [RW-1:0]        gemm_rs2;
    logic [RW-1:0]        gemm_rs3;
    logic                 gemm_done;
    logic [NUM_MREGS-1:0] sb_busy;
    logic                 idle;
    logic [PERF_W-1:0]    perf_issued;
    logic [PERF_W-1:0]    perf_stall;

    modport master (
        output dec_valid, dec_is_gemm, dec_mem_type, dec_rd, dec_rs1,
               dec_rs2, dec_rs3, dec_stride, flush,
               mls_ready, mls_done, gemm_ready, gemm_done,
        input  dec_ready, mls_valid, mls_is_store, mls_reg, mls_stride,
               gemm_valid, gemm_rd, gemm_rs1, gemm_rs2, gemm_rs3,
               sb_busy, idle, perf_issued, perf_stall
    );

    modport slave (
        input  dec_valid, dec_is_gemm, dec_mem_type, dec_rd, dec_rs1,
               dec_rs2, dec_rs3, dec_stride, flush,
               mls_ready, mls_done, gemm_ready, gemm_done,
        output dec_ready, mls_valid, mls_is_store, mls_reg, mls_stride,
               gemm_valid, gemm_rd, gemm_rs1, gemm_rs2, gemm_rs3,
               sb_busy, idle, perf_issued, perf_stall
    );
endinterface

// File: rtl/matrix_issue_scheduler.sv
// In-order single-issue scheduler for matrix ops: one-entry op buffer,
// matrix-register scoreboard, RAW/WAW/WAR + structural checks, issue to MLS/GEMM.
// Ports: CLK, RST (sync, active-high), bus (slave modport: decode in,
// MLS/GEMM valid/ready/done, sb_busy, idle, perf_issued/perf_stall).
// Optional: define MATRIX_SCHED_PERF_EN for saturating issue/stall counters;
// otherwise perf outputs are tied to 0.
module matrix_issue_scheduler #(
    parameter int NUM_MREGS = 16,
    parameter int PERF_W    = 32
) (
    input logic                     CLK,
    input logic                     RST,
    matrix_issue_scheduler_if.slave bus
);
    localparam int RW = $clog2(NUM_MREGS);

    typedef enum logic {
        FU_FREE = 1'b0,
        FU_BUSY = 1'b1
    } fu_state_e;

    fu_state_e mls_st, mls_st_nx;
    fu_state_e gemm_st, gemm_st_nx;

    logic          buf_valid, buf_gemm, buf_store;
    logic [RW-1:0] buf_rd, buf_rs1, buf_rs2, buf_rs3;
    logic [4:0]    buf_stride;

    logic          mls_rec_store;
    logic [RW-1:0] mls_rec_reg;
    logic [RW-1:0] gemm_rec_rd, gemm_rec_rs1, gemm_rec_rs2, gemm_rec_rs3;

    logic [NUM_MREGS-1:0] sb, sb_set, sb_clr;

    logic raw, waw, war, fu_free, go;
    logic mls_hs, gemm_hs, issue_fire, accept, keep;
    logic mls_fin, gemm_fin;

    // Hazards are judged purely on registered state; the buffered op itself
    // is what the FU sees, so valid rises the cycle after accept or done.
    always_comb begin
        raw = 1'b0;
        waw = 1'b0;
        war = 1'b0;
        if (buf_gemm)
            raw = sb[buf_rs1] | sb[buf_rs2] | sb[buf_rs3];
        else if (buf_store)
            raw = sb[buf_rs1];
        if (!buf_store) begin
            waw = sb[buf_rd];
            war = (mls_st == FU_BUSY && mls_rec_store
                   && mls_rec_reg == buf_rd)
               || (gemm_st == FU_BUSY
                   && (gemm_rec_rs1 == buf_rd || gemm_rec_rs2 == buf_rd
                       || gemm_rec_rs3 == buf_rd));
        end
        fu_free = buf_gemm ? (gemm_st == FU_FREE) : (mls_st == FU_FREE);
    end

    assign go         = buf_valid && fu_free && !raw && !waw && !war;
    assign mls_hs     = bus.mls_valid && bus.mls_ready;
    assign gemm_hs    = bus.gemm_valid && bus.gemm_ready;
    assign issue_fire = mls_hs || gemm_hs;
    assign accept     = bus.dec_valid && bus.dec_ready;
    assign keep       = bus.dec_is_gemm || bus.dec_mem_type == 2'b01
                     || bus.dec_mem_type == 2'b10;
    assign mls_fin    = (mls_st == FU_BUSY) && bus.mls_done;
    assign gemm_fin   = (gemm_st == FU_BUSY) && bus.gemm_done;

    assign bus.dec_ready    = !buf_valid || issue_fire;
    assign bus.mls_valid    = go && !buf_gemm;
    assign bus.gemm_valid   = go && buf_gemm;
    assign bus.mls_is_store = buf_store;
    assign bus.mls_reg      = buf_store ? buf_rs1 : buf_rd;
    assign bus.mls_stride   = buf_stride;
    assign bus.gemm_rd      = buf_rd;
    assign bus.gemm_rs1     = buf_rs1;
    assign bus.gemm_rs2     = buf_rs2;
    assign bus.gemm_rs3     = buf_rs3;
    assign bus.sb_busy      = sb;
    assign bus.idle         = !buf_valid && mls_st == FU_FREE
                           && gemm_st == FU_FREE;

    // A done in the handshake cycle completes the op outright.
    always_comb begin
        mls_st_nx  = mls_st;
        gemm_st_nx = gemm_st;
        unique case (mls_st)
            FU_FREE: if (mls_hs && !bus.mls_done) mls_st_nx = FU_BUSY;
            FU_BUSY: if (bus.mls_done) mls_st_nx = FU_FREE;
        endcase
        unique case (gemm_st)
            FU_FREE: if (gemm_hs && !bus.gemm_done) gemm_st_nx = FU_BUSY;
            FU_BUSY: if (bus.gemm_done) gemm_st_nx = FU_FREE;
        endcase
    end

    // Set beats clear when both hit the same register.
    always_comb begin
        sb_set = '0;
        sb_clr = '0;
        if (mls_hs && !buf_store && !bus.mls_done) sb_set[buf_rd] = 1'b1;
        if (gemm_hs && !bus.gemm_done) sb_set[buf_rd] = 1'b1;
        if (mls_fin && !mls_rec_store) sb_clr[mls_rec_reg] = 1'b1;
        if (gemm_fin) sb_clr[gemm_rec_rd] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mls_st  <= FU_FREE;
            gemm_st <= FU_FREE;
            sb      <= '0;
        end else begin
            mls_st  <= mls_st_nx;
            gemm_st <= gemm_st_nx;
            sb      <= (sb & ~sb_clr) | sb_set;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            buf_valid  <= 1'b0;
            buf_gemm   <= 1'b0;
            buf_store  <= 1'b0;
            buf_rd     <= '0;
            buf_rs1    <= '0;
            buf_rs2    <= '0;
            buf_rs3    <= '0;
            buf_stride <= '0;
        end else if (bus.flush) begin
            buf_valid <= 1'b0;
        end else if (accept) begin
            buf_valid  <= keep;
            buf_gemm   <= bus.dec_is_gemm;
            buf_store  <= !bus.dec_is_gemm && bus.dec_mem_type == 2'b10;
            buf_rd     <= bus.dec_rd;
            buf_rs1    <= bus.dec_rs1;
            buf_rs2    <= bus.dec_rs2;
            buf_rs3    <= bus.dec_rs3;
            buf_stride <= bus.dec_stride;
        end else if (issue_fire) begin
            buf_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mls_rec_store <= 1'b0;
            mls_rec_reg   <= '0;
            gemm_rec_rd   <= '0;
            gemm_rec_rs1  <= '0;
            gemm_rec_rs2  <= '0;
            gemm_rec_rs3  <= '0;
        end else begin
            if (mls_hs) begin
                mls_rec_store <= buf_store;
                mls_rec_reg   <= buf_store ? buf_rs1 : buf_rd;
            end
            if (gemm_hs) begin
                gemm_rec_rd  <= buf_rd;
                gemm_rec_rs1 <= buf_rs1;
                gemm_rec_rs2 <= buf_rs2;
                gemm_rec_rs3 <= buf_rs3;
            end
        end
    end

`ifdef MATRIX_SCHED_PERF_EN
    logic [PERF_W-1:0] perf_iss_q, perf_stl_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_iss_q <= '0;
            perf_stl_q <= '0;
        end else begin
            if (issue_fire && perf_iss_q != '1)
                perf_iss_q <= perf_iss_q + 1'b1;
            if (buf_valid && !issue_fire && perf_stl_q != '1)
                perf_stl_q <= perf_stl_q + 1'b1;
        end
    end

    assign bus.perf_issued = perf_iss_q;
    assign bus.perf_stall  = perf_stl_q;
`else
    assign bus.perf_issued = {PERF_W{1'b0}};
    assign bus.perf_stall  = {PERF_W{1'b0}};
`endif
endmodule
